// File: rtl/mc_ctrl.sv
// mc_ctrl -- multi-cycle MIPS control unit.
//
// A Moore FSM steps each instruction through FETCH/DECODE/EXE/MEM/WB and
// drives the datapath enables and selects. The only Mealy term is the beq
// PC load in EXE, which follows the ALU Zero flag.
//
// Optional multiply/divide support is compiled in when MC_CTRL_MULDIV_EN is
// defined. Without it, mult/div/mfhi/mflo decode as illegal (nop), the MD
// outputs are tied low and no busy counter exists.
//
// Handshake: md_start is a single-cycle issue pulse with no ready back from
// the MD unit. The controller tracks occupancy itself with a counter loaded
// to MD_CYCLES on issue. md_busy is high while that counter is nonzero, and
// MD instructions wait in MDWAIT until it drains.
//
// While reset is high every enable (PCWrite, IRWrite, MemWrite, RegWrite,
// md_start) and the illegal pulse are forced low. Asserting reset
// mid-instruction therefore commits nothing.

module mc_ctrl #(
  parameter int MD_CYCLES = 5,
  parameter int ALUOP_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         EXTOp,
  output logic [2:0]         NPCOp,
  output logic               ALUSrc_Sel,
  output logic [1:0]         RegDst_Sel,
  output logic [1:0]         GRFWD_Sel,
  output logic               md_start,
  output logic [1:0]         md_op,
  output logic               md_busy,
  output logic               illegal,
  output logic [2:0]         state
);

  // FSM state encodings
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXE    = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_MDWAIT = 3'd5;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
`ifdef MC_CTRL_MULDIV_EN
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;
`endif

  // ALU operation codes
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_LUI = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(4);

  // Elaboration-time guard on the MD occupancy parameter
  if (MD_CYCLES < 1 || MD_CYCLES > 15) begin : g_md_cycles_range
    $error("mc_ctrl: MD_CYCLES must lie in 1..15");
  end

  logic [2:0] state_q;
  logic [2:0] state_d;

  // Raw (pre-reset-gating) controls
  logic               pcw_raw;
  logic               irw_raw;
  logic               mw_raw;
  logic               rw_raw;
  logic               ill_raw;
  logic               mds_raw;
  logic [1:0]         mdop_raw;
  logic [ALUOP_W-1:0] alu_raw;
  logic [1:0]         ext_raw;
  logic [2:0]         npc_raw;
  logic               src_raw;
  logic [1:0]         rd_raw;
  logic [1:0]         wd_raw;

  // Instruction decode
  logic is_r;
  logic is_add;
  logic is_sub;
  logic is_sll;
  logic is_jr;
  logic is_ori;
  logic is_lui;
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic is_j;
  logic is_jal;
  logic is_mult;
  logic is_div;
  logic is_mfhi;
  logic is_mflo;
  logic is_md_calc;
  logic is_md_move;
  logic is_r_alu;
  logic known;
  logic busy_i;

  assign is_r   = (Op == OP_RTYPE);
  assign is_add = is_r && (Funct == FN_ADD);
  assign is_sub = is_r && (Funct == FN_SUB);
  assign is_sll = is_r && (Funct == FN_SLL);
  assign is_jr  = is_r && (Funct == FN_JR);
  assign is_ori = (Op == OP_ORI);
  assign is_lui = (Op == OP_LUI);
  assign is_lw  = (Op == OP_LW);
  assign is_sw  = (Op == OP_SW);
  assign is_beq = (Op == OP_BEQ);
  assign is_j   = (Op == OP_J);
  assign is_jal = (Op == OP_JAL);

`ifdef MC_CTRL_MULDIV_EN
  assign is_mult = is_r && (Funct == FN_MULT);
  assign is_div  = is_r && (Funct == FN_DIV);
  assign is_mfhi = is_r && (Funct == FN_MFHI);
  assign is_mflo = is_r && (Funct == FN_MFLO);
`else
  assign is_mult = 1'b0;
  assign is_div  = 1'b0;
  assign is_mfhi = 1'b0;
  assign is_mflo = 1'b0;
`endif

  assign is_md_calc = is_mult || is_div;
  assign is_md_move = is_mfhi || is_mflo;
  assign is_r_alu   = is_add || is_sub || is_sll;
  assign known      = is_r_alu || is_jr || is_ori || is_lui || is_lw || is_sw ||
                      is_beq || is_j || is_jal || is_md_calc || is_md_move;

`ifdef MC_CTRL_MULDIV_EN
  logic [3:0] md_cnt;

  // MD occupancy counter: load on issue, then count down and hold at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= 4'd0;
    end else if (mds_raw) begin
      md_cnt <= 4'(MD_CYCLES);
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

  assign busy_i = (md_cnt != 4'd0);
`else
  assign busy_i = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    state_d  = S_FETCH;
    pcw_raw  = 1'b0;
    irw_raw  = 1'b0;
    mw_raw   = 1'b0;
    rw_raw   = 1'b0;
    ill_raw  = 1'b0;
    mds_raw  = 1'b0;
    mdop_raw = 2'b00;
    alu_raw  = ALU_ADD;
    ext_raw  = 2'b00;
    npc_raw  = 3'b000;
    src_raw  = 1'b0;
    rd_raw   = 2'b00;
    wd_raw   = 2'b00;
    case (state_q)
      S_FETCH: begin
        irw_raw = 1'b1;
        pcw_raw = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_j) begin
          pcw_raw = 1'b1;
          npc_raw = 3'b010;
          state_d = S_FETCH;
        end else if (is_jal) begin
          state_d = S_WB;
        end else if (!known) begin
          ill_raw = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (is_r_alu) begin
          alu_raw = is_sub ? ALU_SUB : (is_sll ? ALU_SLL : ALU_ADD);
          state_d = S_WB;
        end else if (is_ori) begin
          alu_raw = ALU_OR;
          src_raw = 1'b1;
          state_d = S_WB;
        end else if (is_lui) begin
          alu_raw = ALU_LUI;
          src_raw = 1'b1;
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          alu_raw = ALU_ADD;
          ext_raw = 2'b01;
          src_raw = 1'b1;
          state_d = S_MEM;
        end else if (is_beq) begin
          alu_raw = ALU_SUB;
          ext_raw = 2'b01;
          npc_raw = 3'b001;
          pcw_raw = Zero;
          state_d = S_FETCH;
        end else if (is_jr) begin
          npc_raw = 3'b011;
          pcw_raw = 1'b1;
          state_d = S_FETCH;
        end else if (is_md_calc) begin
          if (busy_i) begin
            state_d = S_MDWAIT;
          end else begin
            mds_raw  = 1'b1;
            mdop_raw = is_div ? 2'b01 : 2'b00;
            state_d  = S_FETCH;
          end
        end else if (is_md_move) begin
          state_d = busy_i ? S_MDWAIT : S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (is_sw) begin
          mw_raw  = 1'b1;
          state_d = S_FETCH;
        end else if (is_lw) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        if (is_r_alu) begin
          rw_raw = 1'b1;
          rd_raw = 2'b01;
          wd_raw = 2'b00;
        end else if (is_ori || is_lui) begin
          rw_raw = 1'b1;
          rd_raw = 2'b00;
          wd_raw = 2'b00;
        end else if (is_lw) begin
          rw_raw = 1'b1;
          rd_raw = 2'b00;
          wd_raw = 2'b01;
        end else if (is_jal) begin
          rw_raw  = 1'b1;
          rd_raw  = 2'b10;
          wd_raw  = 2'b10;
          pcw_raw = 1'b1;
          npc_raw = 3'b010;
        end else if (is_md_move) begin
          rw_raw   = 1'b1;
          rd_raw   = 2'b01;
          wd_raw   = 2'b11;
          mdop_raw = is_mflo ? 2'b11 : 2'b10;
        end
      end
      S_MDWAIT: begin
        state_d = busy_i ? S_MDWAIT : S_EXE;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Enables and pulses are suppressed for as long as reset is held
  assign PCWrite    = pcw_raw & ~reset;
  assign IRWrite    = irw_raw & ~reset;
  assign MemWrite   = mw_raw & ~reset;
  assign RegWrite   = rw_raw & ~reset;
  assign md_start   = mds_raw & ~reset;
  assign illegal    = ill_raw & ~reset;
  assign ALUOp      = alu_raw;
  assign EXTOp      = ext_raw;
  assign NPCOp      = npc_raw;
  assign ALUSrc_Sel = src_raw;
  assign RegDst_Sel = rd_raw;
  assign GRFWD_Sel  = wd_raw;
  assign md_op      = mdop_raw;
  assign md_busy    = busy_i;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl -- directed bench for mc_ctrl.
// Each instruction pushes its expected per-cycle {state, controls} into a
// queue; the queue is then drained one clock at a time against the DUT.
// The MD sequence is exercised when MC_CTRL_MULDIV_EN is defined.

module tb_mc_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWrite;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic [3:0] ALUOp;
  logic [1:0] EXTOp;
  logic [2:0] NPCOp;
  logic       ALUSrc_Sel;
  logic [1:0] RegDst_Sel;
  logic [1:0] GRFWD_Sel;
  logic       md_start;
  logic [1:0] md_op;
  logic       md_busy;
  logic       illegal;
  logic [2:0] state;

  int    n_tests;
  int    n_fail;
  string cur_tag;

  logic [25:0] exp_q[$];

  // Control vector bit positions for the MD/illegal fields
  localparam logic [22:0] C_ILL  = 23'h000001;
  localparam logic [22:0] C_BUSY = 23'h000002;
  localparam logic [22:0] C_MDS  = 23'h000010;

  mc_ctrl #(.MD_CYCLES(5), .ALUOP_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .ALUOp      (ALUOp),
    .EXTOp      (EXTOp),
    .NPCOp      (NPCOp),
    .ALUSrc_Sel (ALUSrc_Sel),
    .RegDst_Sel (RegDst_Sel),
    .GRFWD_Sel  (GRFWD_Sel),
    .md_start   (md_start),
    .md_op      (md_op),
    .md_busy    (md_busy),
    .illegal    (illegal),
    .state      (state)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed control vector, same field order as cv()
  logic [22:0] obs;
  assign obs = {PCWrite, IRWrite, MemWrite, RegWrite, ALUOp, EXTOp, NPCOp,
                ALUSrc_Sel, RegDst_Sel, GRFWD_Sel, md_start, md_op, md_busy, illegal};

  function automatic logic [22:0] cv(input logic pcw, input logic irw, input logic mw,
                                     input logic rw, input logic [3:0] alu,
                                     input logic [1:0] ext, input logic [2:0] npc,
                                     input logic src, input logic [1:0] rd,
                                     input logic [1:0] wd);
    return {pcw, irw, mw, rw, alu, ext, npc, src, rd, wd, 1'b0, 2'b00, 1'b0, 1'b0};
  endfunction

  function automatic logic [22:0] mdop_bits(input logic [1:0] op);
    logic [22:0] v;
    v = 23'h0;
    v[3:2] = op;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic z);
    cur_tag = tag;
    Op      = op;
    Funct   = fn;
    Zero    = z;
    #1;
  endtask

  task automatic push(input logic [2:0] st, input logic [22:0] c);
    exp_q.push_back({st, c});
  endtask

  task automatic drain();
    logic [25:0] e;
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s c%0d state", cur_tag, cyc), 32'(state), 32'(e[25:23]));
      check($sformatf("%s c%0d ctl", cur_tag, cyc), 32'(obs), 32'(e[22:0]));
      step();
      cyc++;
    end
  endtask

  logic [22:0] c_f;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    c_f     = cv(1, 1, 0, 0, 4'h0, 2'b00, 3'b000, 0, 2'b00, 2'b00);

    // Reset held for two edges with ori on the bus
    reset = 1'b1;
    Op    = 6'b001101;
    Funct = 6'b000000;
    Zero  = 1'b0;
    cur_tag = "reset";
    step();
    step();
    check("reset state", 32'(state), 32'd0);
    check("reset ctl", 32'(obs), 32'd0);
    reset = 1'b0;

    // ori: FETCH DECODE EXE WB
    start("ori", 6'b001101, 6'b000000, 0);
    push(3'd0, c_f);
    push(3'd1, 23'h0);
    push(3'd2, cv(0, 0, 0, 0, 4'b0010, 2'b00, 3'b000, 1, 2'b00, 2'b00));
    push(3'd4, cv(0, 0, 0, 1, 4'b0000, 2'b00, 3'b000, 0, 2'b00, 2'b00));
    drain();

    // lw: five cycles, MEM writes nothing
    start("lw", 6'b100011, 6'b000000, 0);
    push(3'd0, c_f);
    push(3'd1, 23'h0);
    push(3'd2, cv(0, 0, 0, 0, 4'b0000, 2'b01, 3'b000, 1, 2'b00, 2'b00));
    push(3'd3, 23'h0);
    push(3'd4, cv(0, 0, 0, 1, 4'b0000, 2'b00, 3'b000, 0, 2'b00, 2'b01));
    drain();

    // sw: four cycles, MemWrite only in MEM
    start("sw", 6'b101011, 6'b000000, 0);
    push(3'd0, c_f);
    push(3'd1, 23'h0);
    push(3'd2, cv(0, 0, 0, 0, 4'b0000, 2'b01, 3'b000, 1, 2'b00, 2'b00));
    push(3'd3, cv(0, 0, 1, 0, 4'b0000, 2'b00, 3'b000, 0, 2'b00, 2'b00));
    drain();

    // R-type ALU ops
    start("add", 6'b000000, 6'b100000, 0);
    push(3'd0, c_f);
    push(3'd1, 23'h0);
    push(3'd2, cv(0, 0, 0, 0, 4'b0000, 2'b00, 3'b000, 0, 2'b00, 2'b00));
    push(3'd4, cv(0, 0, 0, 1, 4'b0000, 2'b00, 3'b000, 0, 2'b01, 2'b00));
    drain();

    start("sub", 6'b000000, 6'b100010, 0);
    push(3'd0, c_f);
    push(3'd1, 23'h0);
    push(3'd2, cv(0, 0, 0, 0, 4'b0001, 2'b00, 3'b000, 0, 2'b00, 2'b00));
    push(3'd4, cv(0, 0, 0, 1, 4'b0000, 2'b00, 3'b000, 0, 2'b01, 2'b00));
    drain();

    start("sll", 6'b000000, 6'b000000, 0);
    push(3'd0, c_f);
    push(3'd1, 23'h0);
    push(3'd2, cv(0, 0, 0, 0, 4'b0100, 2'b00, 3'b000, 0, 2'b00, 2'b00));
    push(3'd4, cv(0, 0, 0, 1, 4'b0000, 2'b00, 3'b000, 0, 2'b01, 2'b00));
    drain();

    start("lui", 6'b001111, 6'b000000, 0);
    push(3'd0, c_f);
    push(3'd1, 23'h0);
    push(3'd2, cv(0, 0, 0, 0, 4'b0011, 2'b00, 3'b000, 1, 2'b00, 2'b00));
    push(3'd4, cv(0, 0, 0, 1, 4'b0000, 2'b00, 3'b000, 0, 2'b00, 2'b00));
    drain();

    // beq taken and not taken
    start("beq_z1", 6'b000100, 6'b000000, 1);
    push(3'd0, c_f);
    push(3'd1, 23'h0);
    push(3'd2, cv(1, 0, 0, 0, 4'b0001, 2'b01, 3'b001, 0, 2'b00, 2'b00));
    drain();

    start("beq_z0", 6'b000100, 6'b000000, 0);
    push(3'd0, c_f);
    push(3'd1, 23'h0);
    push(3'd2, cv(0, 0, 0, 0, 4'b0001, 2'b01, 3'b001, 0, 2'b00, 2'b00));
    drain();

    // jal: DECODE goes straight to WB
    start("jal", 6'b000011, 6'b000000, 0);
    push(3'd0, c_f);
    push(3'd1, 23'h0);
    push(3'd4, cv(1, 0, 0, 1, 4'b0000, 2'b00, 3'b010, 0, 2'b10, 2'b10));
    drain();

    // j: two cycles, PC load in DECODE
    start("j", 6'b000010, 6'b000000, 0);
    push(3'd0, c_f);
    push(3'd1, cv(1, 0, 0, 0, 4'b0000, 2'b00, 3'b010, 0, 2'b00, 2'b00));
    drain();

    start("jr", 6'b000000, 6'b001000, 0);
    push(3'd0, c_f);
    push(3'd1, 23'h0);
    push(3'd2, cv(1, 0, 0, 0, 4'b0000, 2'b00, 3'b011, 0, 2'b00, 2'b00));
    drain();

    // Unknown opcode: illegal pulse in DECODE only
    start("bad_op", 6'b111111, 6'b000000, 0);
    push(3'd0, c_f);
    push(3'd1, C_ILL);
    drain();

    // Reset asserted during MEM of sw
    start("sw_rst", 6'b101011, 6'b000000, 0);
    push(3'd0, c_f);
    push(3'd1, 23'h0);
    push(3'd2, cv(0, 0, 0, 0, 4'b0000, 2'b01, 3'b000, 1, 2'b00, 2'b00));
    drain();
    reset = 1'b1;
    #1;
    check("sw_rst mem state", 32'(state), 32'd3);
    check("sw_rst mem ctl", 32'(obs), 32'd0);
    step();
    check("sw_rst after state", 32'(state), 32'd0);
    check("sw_rst after ctl", 32'(obs), 32'd0);
    reset = 1'b0;
    #1;
    check("sw_rst release ctl", 32'(obs), 32'(c_f));

`ifdef MC_CTRL_MULDIV_EN
    // mult issues in EXE, then mflo waits for the counter to drain
    start("mult", 6'b000000, 6'b011000, 0);
    push(3'd0, c_f);
    push(3'd1, 23'h0);
    push(3'd2, C_MDS | mdop_bits(2'b00));
    drain();
    start("mflo", 6'b000000, 6'b010010, 0);
    push(3'd0, c_f | C_BUSY);
    push(3'd1, C_BUSY);
    push(3'd2, C_BUSY);
    push(3'd5, C_BUSY);
    push(3'd5, C_BUSY);
    push(3'd5, 23'h0);
    push(3'd2, 23'h0);
    push(3'd4, cv(0, 0, 0, 1, 4'b0000, 2'b00, 3'b000, 0, 2'b01, 2'b11) | mdop_bits(2'b11));
    drain();
`else
    // Without the MD unit, mult is an unknown encoding
    start("mult_ill", 6'b000000, 6'b011000, 0);
    push(3'd0, c_f);
    push(3'd1, C_ILL);
    drain();
`endif

    check("end state", 32'(state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle MIPS control unit; generational successor to the single-cycle decoder.
- Moore FSM sequences FETCH/DECODE/EXE/MEM/WB per instruction and drives the same datapath select/enable set, plus PCWrite/IRWrite.
- Optional multiply/divide unit is tracked by a busy counter.
- Sits between the instruction register (Op/Funct from latched IR) and the multi-cycle datapath (PC, IR, ALU, DM, GRF, NPC).

Parameters:
- MD_CYCLES, 5, cycles mult/div occupies the MD unit after issue (legal range 1..15).
- ALUOP_W, 4, ALUOp width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Op  in  6  IR[31:26], stable from end of FETCH until next FETCH.
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU equality flag for beq, valid in EXE.
- PCWrite  out  1  PC load enable.
- IRWrite  out  1  IR load enable.
- MemWrite  out  1  DM write enable.
- RegWrite  out  1  GRF write enable.
- ALUOp  out  ALUOP_W  0000 add, 0001 sub, 0010 or, 0011 lui, 0100 sll.
- EXTOp  out  2  00 zero-ext, 01 sign-ext.
- NPCOp  out  3  000 PC+4, 001 beq, 010 j/jal, 011 jr.
- ALUSrc_Sel  out  1  1 = extended immediate.
- RegDst_Sel  out  2  00 rt, 01 rd, 10 $31.
- GRFWD_Sel  out  2  00 ALU, 01 DM, 10 PC+4, 11 HI/LO.
- md_start  out  1  one-cycle issue pulse to MD unit.
- md_op  out  2  00 mult, 01 div, 10 mfhi, 11 mflo.
- md_busy  out  1  MD counter nonzero.
- illegal  out  1  one-cycle pulse in DECODE for unknown encoding.
- state  out  3  current state, for debug/verification.

Behaviour:
- States: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4, MDWAIT=5. Encodings 6/7 go to FETCH next cycle with all enables 0.
- reset=1 at an edge: state<=FETCH, md counter<=0. While reset is high all enables are forced to 0. This applies mid-instruction too: nothing is written and no partial PC update occurs.
- All outputs are combinational functions of state, Op, Funct and Zero (Moore, except beq PCWrite).
- Non-enable selects default to 0 outside their active state.
- FETCH: IRWrite=1, PCWrite=1, NPCOp=000. Next state DECODE.
- DECODE sequence:
  - j: PCWrite=1, NPCOp=010, then FETCH.
  - jal: go to WB.
  - Unknown encoding: illegal=1, then FETCH (behaves as nop).
  - All others: go to EXE.
- EXE, per instruction:
  - add/sub/sll: ALUOp per table; next WB.
  - ori: EXTOp=00, ALUSrc=1; next WB.
  - lui: ALUSrc=1; next WB.
  - lw/sw: EXTOp=01, ALUSrc=1, ALUOp=0000; next MEM.
  - beq: ALUOp=0001, EXTOp=01, NPCOp=001, PCWrite=Zero; next FETCH.
  - jr: NPCOp=011, PCWrite=1; next FETCH.
- MEM:
  - sw: MemWrite=1, then FETCH.
  - lw: go to WB.
- WB:
  - R-type: RegWrite=1, RegDst=01, GRFWD=00.
  - ori/lui: RegDst=00, GRFWD=00.
  - lw: RegDst=00, GRFWD=01.
  - jal: RegDst=10, GRFWD=10, PCWrite=1, NPCOp=010.
  - Next state FETCH.
- Cycle counts: j 2; beq, jr, jal 3; R-type ALU, ori, lui, sw 4; lw 5.

Optional Feature:
- Macro: MC_CTRL_MULDIV_EN.
- Defined:
  - mult/div (R-type Funct 011000/011010): in EXE, if md_busy=0, md_start=1, md_op set, counter<=MD_CYCLES, then FETCH. If md_busy=1, go to MDWAIT.
  - mfhi/mflo (Funct 010000/010010): if busy, EXE goes to MDWAIT; otherwise WB with RegWrite=1, RegDst=01, GRFWD=11.
  - MDWAIT: holds with all enables 0 until counter reaches 0, then re-enters EXE.
  - Counter decrements by 1 per cycle while nonzero and saturates at 0.
  - md_busy = (counter != 0).
- Not defined: the four encodings decode as illegal (nop). md_start, md_busy and md_op are tied to 0 and no counter is built.

Test Plan:
- reset held 2 cycles, then released with Op=ori → state 0,1,2,4,0. RegWrite=1 only in WB; EXTOp=00 and ALUSrc=1 in EXE.
- lw (Op=100011) → 5 cycles; MEM has MemWrite=0; WB has GRFWD=01, RegDst=00. sw (101011) → MemWrite=1 in MEM only, 4 cycles.
- beq with Zero=1 → PCWrite=1, NPCOp=001 in EXE. With Zero=0 → PCWrite=0. Both return to FETCH after 3 cycles.
- jal → WB has RegDst=10, GRFWD=10, PCWrite=1, NPCOp=010. j → PCWrite in DECODE, 2 cycles total.
- Op=111111 → illegal pulse in DECODE, no enables asserted. reset asserted in MEM of sw → MemWrite=0 that cycle; state=FETCH next.
- With MC_CTRL_MULDIV_EN and MD_CYCLES=5: mult then immediate mflo → mflo waits in MDWAIT until md_busy=0, then WB asserts GRFWD=11. Without the macro, mult raises illegal.
